jt6295_ch_seq: RTL and testbench

- Four-channel, time-multiplexed ADPCM playback sequencer.
- Sits directly downstream of the phrase-table controller. It accepts start and stop requests with 18-bit start/stop byte addresses and attenuation, and reports busy/ack back to the controller.
- Walks sample ROM one nibble per channel per sample period.
- Hands a nibble stream (channel, attenuation, restart flag) to the ADPCM decoder.

---
 rtl/jt6295_pkg.sv | 23 ++
 rtl/jt6295_ch_regs.sv | 67 ++++++
 rtl/jt6295_ch_seq.sv | 152 +++++++++++++++
 tb/tb_jt6295_ch_seq.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jt6295_pkg.sv
// Shared definitions for the jt6295 channel sequencer: channel count, address
// width, FSM state and nibble-select encodings.
package jt6295_pkg;

  localparam int NCH    = 4;
  localparam int AW_DEF = 18;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_EMIT = 2'd2
  } state_t;

  typedef enum logic {
    NIB_LO = 1'b0,
    NIB_HI = 1'b1
  } nib_sel_t;

  function automatic logic [3:0] pick_nibble(input logic [7:0] b, input nib_sel_t sel);
    return (sel == NIB_HI) ? b[7:4] : b[3:0];
  endfunction

endpackage

// File: rtl/jt6295_ch_regs.sv
// Four-entry per-channel playback state, read and written at the slot index.
// load/stop/adv are mutually exclusive in practice; load has priority.
module jt6295_ch_regs
  import jt6295_pkg::*;
#(
  parameter int AW = AW_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [1:0]     idx,
  input  logic           load,
  input  logic [AW-1:0]  load_addr,
  input  logic [AW-1:0]  load_end,
  input  logic [3:0]     load_att,
  input  logic           stop,
  input  logic           adv,
  output logic [AW-1:0]  addr,
  output logic [3:0]     att,
  output nib_sel_t       hi,
  output logic           first,
  output logic [NCH-1:0] busy
);

  logic [AW-1:0]  addr_r [NCH];
  logic [AW-1:0]  end_r  [NCH];
  logic [3:0]     att_r  [NCH];
  logic [NCH-1:0] hi_r;
  logic [NCH-1:0] first_r;
  logic [NCH-1:0] busy_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        addr_r[i] <= '0;
        end_r[i]  <= '0;
        att_r[i]  <= '0;
      end
      hi_r    <= '0;
      first_r <= '0;
      busy_r  <= '0;
    end else if (load) begin
      addr_r[idx]  <= load_addr;
      end_r[idx]   <= load_end;
      att_r[idx]   <= load_att;
      hi_r[idx]    <= 1'b1;
      first_r[idx] <= 1'b1;
      busy_r[idx]  <= 1'b1;
    end else if (stop) begin
      busy_r[idx] <= 1'b0;
    end else if (adv) begin
      first_r[idx] <= 1'b0;
      hi_r[idx]    <= ~hi_r[idx];
      // Low nibble done: the byte is consumed, move on or finish the phrase.
      if (!hi_r[idx]) begin
        if (addr_r[idx] == end_r[idx]) busy_r[idx] <= 1'b0;
        else addr_r[idx] <= addr_r[idx] + 1'b1;
      end
    end
  end

  assign addr  = addr_r[idx];
  assign att   = att_r[idx];
  assign hi    = nib_sel_t'(hi_r[idx]);
  assign first = first_r[idx];
  assign busy  = busy_r;

endmodule

// File: rtl/jt6295_ch_seq.sv
// Four-channel time-multiplexed ADPCM nibble sequencer. Define
// JT6295_NIBBLE_CACHE_EN to serve low nibbles from a per-channel byte cache.
module jt6295_ch_seq
  import jt6295_pkg::*;
#(
  parameter int AW = AW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cen4,
  input  logic          cen1,
  input  logic [3:0]    start,
  input  logic [3:0]    stop,
  input  logic [AW-1:0] start_addr,
  input  logic [AW-1:0] stop_addr,
  input  logic [3:0]    att,
  output logic [3:0]    busy,
  output logic [3:0]    ack,
  output logic [AW-1:0] rom_addr,
  output logic          rom_cs,
  input  logic [7:0]    rom_data,
  input  logic          rom_ok,
  output logic          dec_valid,
  output logic [1:0]    dec_ch,
  output logic [3:0]    dec_nibble,
  output logic [3:0]    dec_att,
  output logic          dec_restart,
  output logic [1:0]    dbg_state
);

  state_t        state;
  logic [1:0]    slot, nslot, idx;
  logic          guard;
  logic          do_load, do_stop, do_adv, busy_after, capture, cache_hit;
  logic [AW-1:0] rd_addr;
  logic [3:0]    rd_att;
  nib_sel_t      rd_hi;
  logic          rd_first;
  logic [7:0]    emit_byte;

  // On a cen4 clk the register file is already addressed by the slot being opened.
  always_comb begin
    nslot      = cen1 ? 2'd0 : slot + 2'd1;
    idx        = cen4 ? nslot : slot;
    do_load    = cen4 & start[idx] & ~busy[idx];
    do_stop    = cen4 & ~start[idx] & stop[idx];
    busy_after = do_load | (busy[idx] & ~do_stop);
    capture    = ~cen4 & (state == ST_REQ) & ~guard & rom_ok;
  end

`ifdef JT6295_NIBBLE_CACHE_EN
  logic [7:0]     cache_byte [NCH];
  logic [NCH-1:0] cache_vld;

  assign cache_hit = cen4 & busy_after & ~do_load & (rd_hi == NIB_LO) & cache_vld[idx];
  assign emit_byte = cache_hit ? cache_byte[idx] : rom_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) cache_byte[i] <= '0;
      cache_vld <= '0;
    end else if (do_load) begin
      cache_vld[idx] <= 1'b0;
    end else if (capture) begin
      cache_byte[idx] <= rom_data;
      cache_vld[idx]  <= 1'b1;
    end
  end
`else
  assign cache_hit = 1'b0;
  assign emit_byte = rom_data;
`endif

  assign do_adv = capture | cache_hit;

  jt6295_ch_regs #(.AW(AW)) u_regs (
    .clk       (clk),
    .rst_n     (rst_n),
    .idx       (idx),
    .load      (do_load),
    .load_addr (start_addr),
    .load_end  (stop_addr),
    .load_att  (att),
    .stop      (do_stop),
    .adv       (do_adv),
    .addr      (rd_addr),
    .att       (rd_att),
    .hi        (rd_hi),
    .first     (rd_first),
    .busy      (busy)
  );

  // A cen4 always opens a new slot, whatever the FSM was doing; a pending
  // fetch is then a miss and is simply dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      slot        <= 2'd0;
      guard       <= 1'b0;
      rom_cs      <= 1'b0;
      rom_addr    <= '0;
      ack         <= 4'd0;
      dec_valid   <= 1'b0;
      dec_ch      <= 2'd0;
      dec_nibble  <= 4'd0;
      dec_att     <= 4'd0;
      dec_restart <= 1'b0;
    end else begin
      ack       <= 4'd0;
      dec_valid <= 1'b0;
      if (cen4) begin
        slot  <= nslot;
        guard <= 1'b0;
        if (start[idx]) ack <= 4'b0001 << idx;
        if (cache_hit) begin
          rom_cs <= 1'b0;
          state  <= ST_EMIT;
        end else if (busy_after) begin
          rom_addr <= do_load ? start_addr : rd_addr;
          rom_cs   <= 1'b1;
          guard    <= 1'b1;
          state    <= ST_REQ;
        end else begin
          rom_cs <= 1'b0;
          state  <= ST_IDLE;
        end
      end else begin
        case (state)
          ST_REQ: begin
            if (guard) guard <= 1'b0;
            else if (rom_ok) begin
              rom_cs <= 1'b0;
              state  <= ST_EMIT;
            end
          end
          ST_EMIT: state <= ST_IDLE;
          default: ;
        endcase
      end
      if (do_adv) begin
        dec_valid   <= 1'b1;
        dec_ch      <= idx;
        dec_att     <= rd_att;
        dec_restart <= rd_first;
        dec_nibble  <= pick_nibble(emit_byte, rd_hi);
      end
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_jt6295_ch_seq.sv
// Bench for jt6295_ch_seq: phrase-level reference model feeding an expected
// queue, with an independent monitor popping on every dec_valid.
module tb_jt6295_ch_seq;

  logic        clk, rst_n, cen4, cen1;
  logic [3:0]  start, stop, att;
  logic [17:0] start_addr, stop_addr;
  logic [3:0]  busy, ack;
  logic [17:0] rom_addr;
  logic        rom_cs, rom_ok;
  logic [7:0]  rom_data;
  logic        dec_valid, dec_restart;
  logic [1:0]  dec_ch, dbg_state;
  logic [3:0]  dec_nibble, dec_att;

  jt6295_ch_seq dut (
    .clk(clk), .rst_n(rst_n), .cen4(cen4), .cen1(cen1),
    .start(start), .stop(stop), .start_addr(start_addr), .stop_addr(stop_addr),
    .att(att), .busy(busy), .ack(ack), .rom_addr(rom_addr), .rom_cs(rom_cs),
    .rom_data(rom_data), .rom_ok(rom_ok), .dec_valid(dec_valid), .dec_ch(dec_ch),
    .dec_nibble(dec_nibble), .dec_att(dec_att), .dec_restart(dec_restart),
    .dbg_state(dbg_state)
  );

  int total = 0;
  int bad   = 0;
  // entry: {last, ch[1:0], att[3:0], restart, nibble[3:0]}
  logic [11:0] exp_q[$];
  logic [7:0]  rom_ovr [logic [17:0]];
  logic [17:0] rd_log[$];
  int          emit_cnt [4];
  int          req_cnt = 0;
  int          ph, cur_ph;
  bit          hold_off = 0;
  bit          rand_lat = 0;

  // ---------------- clock / slot strobes ----------------
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    cen4 = 0; cen1 = 0; ph = 0; cur_ph = 0;
    forever begin
      @(negedge clk);
      cen4   = (ph % 8 == 0);
      cen1   = (ph == 0);
      cur_ph = ph;
      ph     = (ph + 1) % 32;
    end
  end

  // ---------------- ROM model ----------------
  function automatic logic [7:0] rom_byte(input logic [17:0] a);
    if (rom_ovr.exists(a)) return rom_ovr[a];
    return a[7:0] ^ {a[14:8], 1'b0} ^ {6'd0, a[17:16]} ^ 8'h5A;
  endfunction

  initial begin
    logic        prev_cs;
    logic [17:0] prev_addr;
    int          cnt, lat;
    rom_ok = 0; rom_data = 0; prev_cs = 0; prev_addr = 0; cnt = 0; lat = 1;
    forever begin
      @(negedge clk);
      if (rom_cs && (!prev_cs || rom_addr != prev_addr)) begin
        cnt = 0;
        lat = rand_lat ? int'($urandom_range(1, 8)) : 1;
        req_cnt++;
        rd_log.push_back(rom_addr);
      end else if (rom_cs) cnt++;
      prev_cs   = rom_cs;
      prev_addr = rom_addr;
      rom_data  = rom_byte(rom_addr);
      rom_ok    = rom_cs && !hold_off && (cnt >= lat);
    end
  end

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h t=%0t", name, got, want, $time);
    end
  endtask

  function automatic int pending(input int n);
    int c = 0;
    foreach (exp_q[i]) if (int'(exp_q[i][10:9]) == n) c++;
    return c;
  endfunction

  task automatic drop_ch(input int n);
    for (int i = exp_q.size() - 1; i >= 0; i--)
      if (int'(exp_q[i][10:9]) == n) exp_q.delete(i);
  endtask

  // A phrase is every byte from sa to ea inclusive (wrapping), high nibble first.
  task automatic push_phrase(input int n, input logic [17:0] sa, input logic [17:0] ea,
                             input logic [3:0] a);
    logic [17:0] span, ad;
    logic [7:0]  b;
    logic [1:0]  c;
    span = ea - sa;
    c    = 2'(n);
    for (int i = 0; i <= int'(span); i++) begin
      ad = sa + 18'(i);
      b  = rom_byte(ad);
      exp_q.push_back({1'b0, c, a, (i == 0), b[7:4]});
      exp_q.push_back({(i == int'(span)), c, a, 1'b0, b[3:0]});
    end
  endtask

  // ---------------- monitor ----------------
  initial begin
    int k;
    forever begin
      @(negedge clk);
      if (dec_valid === 1'b1) begin
        emit_cnt[dec_ch]++;
        k = -1;
        foreach (exp_q[i]) if (k < 0 && exp_q[i][10:9] == dec_ch) k = i;
        if (k < 0) begin
          total++; bad++;
          $display("FAIL dec_unexpected: ch=%0d nibble=%0h required=none t=%0t",
                   dec_ch, dec_nibble, $time);
        end else begin
          chk("dec_word", {21'd0, dec_ch, dec_att, dec_restart, dec_nibble}, {21'd0, exp_q[k][10:0]});
          chk("busy_at_emit", {31'd0, busy[dec_ch]}, {31'd0, ~exp_q[k][11]});
          exp_q.delete(k);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start_ch(input int n, input logic [17:0] sa, input logic [17:0] ea,
                          input logic [3:0] a);
    bit got = 0;
    @(negedge clk); #1;
    start_addr = sa; stop_addr = ea; att = a; start[n] = 1'b1;
    for (int i = 0; i < 80 && !got; i++) begin
      @(posedge clk); #1;
      if (ack != 4'd0) begin
        got = 1;
        chk("ack_onehot", {28'd0, ack}, 32'd1 << n);
        start[n] = 1'b0;
        if (pending(n) == 0) push_phrase(n, sa, ea, a);
        @(posedge clk); #1;
        chk("ack_pulse_width", {28'd0, ack}, 32'd0);
      end
    end
    start[n] = 1'b0;
    chk("ack_seen", {31'd0, got}, 32'd1);
  endtask

  task automatic wait_slot_open(input int n);
    bit found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk); #1;
      if (cen4 && cur_ph == 8 * n) found = 1;
    end
    chk("slot_open_seen", {31'd0, found}, 32'd1);
  endtask

  task automatic stop_ch(input int n);
    wait_slot_open(n);
    stop[n] = 1'b1;
    drop_ch(n);
    @(posedge clk); #1;
    stop[n] = 1'b0;
    chk("busy_after_stop", {31'd0, busy[n]}, 32'd0);
  endtask

  task automatic wait_emits(input int n, input int target);
    for (int i = 0; i < 2000 && emit_cnt[n] < target; i++) @(negedge clk);
    chk("emit_progress", {31'd0, emit_cnt[n] >= target}, 32'd1);
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget && exp_q.size() > 0; i++) @(negedge clk);
    cycles(4);
    chk("drain_empty", exp_q.size(), 32'd0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_busy_ack_cs"}, {23'd0, busy, ack, rom_cs}, 32'd0);
    chk({tag, "_rom_addr"}, {14'd0, rom_addr}, 32'd0);
    chk({tag, "_dec"}, {20'd0, dec_valid, dec_ch, dec_nibble, dec_att, dec_restart}, 32'd0);
    chk({tag, "_state"}, {30'd0, dbg_state}, 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int          snap, exp_req;
    logic [17:0] comp[$];
    logic [17:0] sa;
    rst_n = 0; start = 0; stop = 0; start_addr = 0; stop_addr = 0; att = 0;
    foreach (emit_cnt[i]) emit_cnt[i] = 0;
    rom_ovr[18'h00100] = 8'hA5;
    rom_ovr[18'h00101] = 8'h3C;

    cycles(3);
    check_zero("reset");
    rst_n = 1;
    cycles(40);

    // Two-byte phrase on ch1: A,5,3,C with restart only on A.
    snap = req_cnt;
    start_ch(1, 18'h00100, 18'h00101, 4'd3);
    wait_drain(600);
`ifdef JT6295_NIBBLE_CACHE_EN
    exp_req = 2;
`else
    exp_req = 4;
`endif
    chk("rom_reqs_phrase1", req_cnt - snap, exp_req);
    chk("busy_end_phrase1", {28'd0, busy}, 32'd0);

    // Stop ch2 mid-phrase.
    start_ch(2, 18'h00800, 18'h00807, 4'd6);
    wait_emits(2, 3);
    stop_ch(2);
    snap = emit_cnt[2];
    cycles(120);
    chk("no_emit_after_stop", emit_cnt[2], snap);

    // ROM withheld for a whole ch0 slot: no emission, then the same nibble.
    start_ch(0, 18'h01230, 18'h01231, 4'd1);
    hold_off = 1;
    snap = emit_cnt[0];
    wait_slot_open(1);
    hold_off = 0;
    chk("no_emit_on_miss", emit_cnt[0], snap);
    wait_drain(800);

    // Start on a busy channel is acked and discarded.
    start_ch(3, 18'h02000, 18'h02003, 4'd9);
    wait_emits(3, 2);
    start_ch(3, 18'h03000, 18'h03001, 4'd2);
    wait_drain(1200);
    chk("busy3_after_phrase", {31'd0, busy[3]}, 32'd0);

    // Address wrap at the top of ROM.
    rd_log.delete();
    start_ch(1, 18'h3FFFF, 18'h00000, 4'd5);
    wait_drain(800);
    foreach (rd_log[i]) if (comp.size() == 0 || comp[comp.size()-1] != rd_log[i]) comp.push_back(rd_log[i]);
    chk("wrap_distinct_reads", comp.size(), 32'd2);
    if (comp.size() >= 2) begin
      chk("wrap_read0", {14'd0, comp[0]}, 32'h3FFFF);
      chk("wrap_read1", {14'd0, comp[1]}, 32'h00000);
    end

    // Reset while a fetch is outstanding.
    start_ch(2, 18'h00500, 18'h00503, 4'd7);
    hold_off = 1;
    #1 rst_n = 0;
    #1 check_zero("async_reset");
    drop_ch(2);
    hold_off = 0;
    cycles(2);
    rst_n = 1;
    cycles(80);
    chk("idle_after_reset", {28'd0, busy}, 32'd0);

    // Randomised mix of starts and stops with variable ROM latency.
    rand_lat = 1;
    for (int it = 0; it < 14; it++) begin
      int n;
      n = int'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) stop_ch(n);
      else begin
        sa = 18'($urandom_range(0, 32'h3FFFF));
        start_ch(n, sa, sa + 18'($urandom_range(0, 2)), 4'($urandom_range(0, 15)));
      end
      cycles(int'($urandom_range(0, 60)));
    end
    wait_drain(4000);
    chk("final_busy", {28'd0, busy}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
